// File: rtl/_ser2par_load_if.sv
// Serial-in / parallel-out bundle for _ser2par_load.
// master drives the serial side; slave (the load stage) drives the bank side.
interface _ser2par_load_if #(
    parameter int unsigned WIDTH = 8
);
    logic             bit_valid;
    logic             bit_in;
    logic             sof;
    logic             out_en;
    logic [WIDTH-1:0] out_d;
    logic             busy;
    logic             err;

    modport master (
        output bit_valid, bit_in, sof,
        input  out_en, out_d, busy, err
    );

    modport slave (
        input  bit_valid, bit_in, sof,
        output out_en, out_d, busy, err
    );
endinterface

// File: rtl/_ser2par_load.sv
// Serial-to-parallel load stage: assembles an LSB-first framed bit stream and pulses out_en.
// Optional even-parity gate compiled in with `define PARITY_EN.
module _ser2par_load #(
    parameter int unsigned WIDTH = 8
) (
    input logic                  clk_i,
    input logic                  reset_i,
    _ser2par_load_if.slave       bus_io
);
    localparam int unsigned         CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0]     LastCnt = CntW'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [WIDTH-1:0]  out_d_q, out_d_d;
    logic              out_en_q, out_en_d;
`ifdef PARITY_EN
    logic              par_q, par_d;
    logic              err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        out_d_d  = out_d_q;
        out_en_d = 1'b0;
`ifdef PARITY_EN
        par_d    = par_q;
        err_d    = 1'b0;
`endif
        if (bus_io.bit_valid) begin
            if (bus_io.sof) begin
                // sof restarts from any state; the partial frame is dropped silently
                sr_d    = WIDTH'(bus_io.bit_in);
                cnt_d   = CntW'(1);
                state_d = StShift;
`ifdef PARITY_EN
                par_d   = bus_io.bit_in;
`endif
            end else begin
                unique case (state_q)
                    StIdle: begin
                    end
                    StShift: begin
                        sr_d  = sr_q | (WIDTH'(bus_io.bit_in) << cnt_q);
                        cnt_d = cnt_q + CntW'(1);
`ifdef PARITY_EN
                        par_d = par_q ^ bus_io.bit_in;
                        if (cnt_q == LastCnt) begin
                            state_d = StParity;
                        end
`else
                        if (cnt_q == LastCnt) begin
                            out_d_d  = sr_d;
                            out_en_d = 1'b1;
                            cnt_d    = '0;
                            state_d  = StIdle;
                        end
`endif
                    end
`ifdef PARITY_EN
                    StParity: begin
                        // par_q already covers all data bits; even parity means XOR is 0
                        if (par_q ^ bus_io.bit_in) begin
                            err_d = 1'b1;
                        end else begin
                            out_d_d  = sr_q;
                            out_en_d = 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = StIdle;
                    end
`endif
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sr_q     <= '0;
            out_d_q  <= '0;
            out_en_q <= 1'b0;
`ifdef PARITY_EN
            par_q    <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            out_d_q  <= out_d_d;
            out_en_q <= out_en_d;
`ifdef PARITY_EN
            par_q    <= par_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus_io.out_en = out_en_q;
    assign bus_io.out_d  = out_d_q;
    assign bus_io.busy   = (state_q != StIdle);
`ifdef PARITY_EN
    assign bus_io.err    = err_q;
`else
    assign bus_io.err    = 1'b0;
`endif
endmodule

// File: tb/tb__ser2par_load.sv
// Self-checking bench for _ser2par_load: frame-level reference model, vector table,
// directed corner sequences and a randomized stream.
module tb__ser2par_load;
    localparam int unsigned W = 8;
`ifdef PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    _ser2par_load_if #(.WIDTH(W)) bus ();
    _ser2par_load #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus_io  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cycle = 0, pulses = 0, err_pulses = 0, busy_cnt = 0, last_pulse = -1, pulse_gap = 0;
    logic [W-1:0] pulse_ds[$];

    // Reference model: a frame is the list of bits received since the last sof.
    bit           m_act = 1'b0;
    bit           m_bits[$];
    logic [W-1:0] m_d = '0;
    logic         m_en = 1'b0, m_err = 1'b0;

    typedef struct {
        logic [W-1:0] data;
        int           gap;
        logic [W-1:0] exp_d;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic model(input logic r, input logic v, input logic s, input logic b);
        m_en  = 1'b0;
        m_err = 1'b0;
        if (r) begin
            m_act = 1'b0;
            m_bits.delete();
            m_d = '0;
        end else if (v) begin
            if (s) begin
                m_bits.delete();
                m_bits.push_back(b);
                m_act = 1'b1;
            end else if (m_act) begin
                m_bits.push_back(b);
                if (m_bits.size() == FB) begin
                    logic [W-1:0] w    = '0;
                    int           ones = 0;
                    bit           ok   = 1'b1;
                    for (int i = 0; i < W; i++) w = w + (W'(m_bits[i]) << i);
                    for (int i = 0; i < FB; i++) ones += int'(m_bits[i]);
`ifdef PARITY_EN
                    ok = (ones % 2 == 0);
`endif
                    if (ok) begin
                        m_d  = w;
                        m_en = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_act = 1'b0;
                    m_bits.delete();
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic s, input logic b);
        rst           = r;
        bus.bit_valid = v;
        bus.sof       = s;
        bus.bit_in    = b;
        @(posedge clk);
        model(r, v, s, b);
        #1;
        cycle++;
        check("cycle_outputs", {53'd0, bus.out_en, bus.err, bus.busy, bus.out_d},
              {53'd0, m_en, m_err, m_act, m_d});
        if (bus.out_en === 1'b1) begin
            pulses++;
            pulse_ds.push_back(bus.out_d);
            if (last_pulse >= 0) pulse_gap = cycle - last_pulse;
            last_pulse = cycle;
        end
        if (bus.err === 1'b1) err_pulses++;
        if (bus.busy === 1'b1) busy_cnt++;
    endtask

    task automatic clear_stats();
        pulses = 0; err_pulses = 0; busy_cnt = 0; last_pulse = -1; pulse_gap = 0;
        pulse_ds.delete();
    endtask

    // One frame; gap idle cycles between bits; bad_par flips the parity bit when present.
    task automatic send(input logic [W-1:0] data, input int gap, input bit bad_par);
        for (int k = 0; k < FB; k++) begin
            logic b;
            if (k < W) b = data[k];
            else       b = (^data) ^ bad_par;
            cyc(1'b0, 1'b1, (k == 0), b);
            if (k < FB - 1)
                for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, $urandom_range(0, 1), $urandom_range(0, 1));
        end
    endtask

    initial begin
        vecs[0] = '{data: 8'h3C, gap: 2, exp_d: 8'h3C};
        vecs[1] = '{data: 8'hFF, gap: 0, exp_d: 8'hFF};
        vecs[2] = '{data: 8'h00, gap: 1, exp_d: 8'h00};
        vecs[3] = '{data: 8'h81, gap: 3, exp_d: 8'h81};

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_state", {bus.out_en, bus.err, bus.busy, bus.out_d}, 11'd0);

        // Continuous A5 frame
        clear_stats();
        send(8'hA5, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("a5_pulses", pulses, 1);
        check("a5_out_d", bus.out_d, 8'hA5);
        check("a5_busy_cycles", busy_cnt, FB - 1);
        check("a5_err", err_pulses, 0);

        foreach (vecs[i]) begin
            clear_stats();
            send(vecs[i].data, vecs[i].gap, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            check("vec_pulses", pulses, 1);
            check("vec_out_d", bus.out_d, vecs[i].exp_d);
        end

        // Truncated frame superseded by a new sof
        clear_stats();
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        send(8'h3C, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_pulses", pulses, 1);
        check("restart_out_d", bus.out_d, 8'h3C);

        // Reset mid-frame
        clear_stats();
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, (k == 0), 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("midreset_pulses", pulses, 0);
        check("midreset_out_d", bus.out_d, 8'h00);
        check("midreset_busy", bus.busy, 1'b0);
        send(8'hFF, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("after_reset_out_d", bus.out_d, 8'hFF);

        // Back-to-back: second sof lands on the out_en cycle
        clear_stats();
        send(8'h01, 0, 1'b0);
        send(8'h80, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b_pulses", pulses, 2);
        check("b2b_gap", pulse_gap, FB);
        if (pulse_ds.size() == 2) begin
            check("b2b_first_d", pulse_ds[0], 8'h01);
            check("b2b_second_d", pulse_ds[1], 8'h80);
        end else begin
            check("b2b_pulse_log", pulse_ds.size(), 2);
        end

`ifdef PARITY_EN
        clear_stats();
        send(8'hA5, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("par_ok_pulses", pulses, 1);
        check("par_ok_out_d", bus.out_d, 8'hA5);
        clear_stats();
        send(8'h5A, 0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("par_bad_pulses", pulses, 0);
        check("par_bad_err", err_pulses, 1);
        check("par_bad_out_d", bus.out_d, 8'hA5);
`endif

        // Randomized stream against the frame model
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 11) == 0), $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/_ser2par_load.md
# _ser2par_load

Serial-to-parallel load stage placed directly upstream of the enabled D flip-flop register bank. It assembles a framed serial bit stream into a WIDTH-bit word. When the word is complete it drives the bank's data inputs (out_d) and pulses the bank's shared enable (out_en) for exactly one cycle. In the build with parity enabled, a parity check gates the load.

## Interface
- WIDTH, 8, data bits per frame; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- bit_valid  input  1  bit_in is sampled on this rising edge.
- bit_in  input  1  serial data, LSB first.
- sof  input  1  start of frame; meaningful only when bit_valid=1; marks bit_in as data bit 0.
- out_en  output  1  one-cycle load pulse to the register bank.
- out_d  output  WIDTH  assembled word; holds its value between pulses.
- busy  output  1  frame in progress (state is not IDLE).
- err  output  1  one-cycle parity-error pulse; constant 0 without PARITY_EN.

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with PARITY_EN). Internal: shift register sr[WIDTH-1:0], bit counter cnt of width clog2(WIDTH)+1, parity accumulator.
- IDLE: if bit_valid and sof, then sr[0] <= bit_in, cnt <= 1, go to SHIFT. A bit with sof=0 is ignored.
- SHIFT: if bit_valid and not sof, then sr[cnt] <= bit_in and cnt <= cnt+1.
  - On the last data bit (cnt == WIDTH-1) without PARITY_EN: out_d <= the assembled word, out_en <= 1, go to IDLE.
  - On the last data bit with PARITY_EN: go to PARITY.
- PARITY: on bit_valid, check even parity (XOR of WIDTH data bits and the parity bit must be 0).
  - Pass: load out_d and pulse out_en.
  - Fail: pulse err; out_d is unchanged.
  - Either way, go to IDLE.
- sof with bit_valid in SHIFT or PARITY: discard the partial frame, take bit_in as new bit 0, cnt <= 1, stay in or enter SHIFT. No out_en, no err.
- bit_valid=0: every state and register holds.
- Reset: state IDLE, cnt=0, sr=0, out_d=0, out_en=0, err=0, busy=0. Reset mid-frame discards the frame with no pulse.

## Timing
- out_en, err and out_d are registered. out_en/err are high for the single cycle after the edge that samples the final bit (last data bit, or the parity bit).
- Load latency is 1 cycle after the final bit. out_d becomes valid in the same cycle out_en rises, so the bank captures it on the next edge.
- busy is a decode of the state register. It rises the cycle after the sof edge and falls the cycle out_en/err rises.
- Back-to-back frames: sof may arrive on the cycle out_en is high (state is IDLE). That frame is accepted with no dead cycle.
- Minimum frame period: WIDTH cycles, or WIDTH+1 with PARITY_EN.
- out_en and err are never high in the same cycle.

## Configuration
- PARITY_EN: when defined, the PARITY state, the even-parity check and the err pulse are compiled in. Each frame is WIDTH+1 bits, and a failed frame produces no load.
- When PARITY_EN is undefined, there is no PARITY state and err is tied to 0. A frame is WIDTH bits, and every complete frame loads.

## Test plan
- Reset, then sof with 0xA5 (bits 1,0,1,0,0,1,0,1), bit_valid continuous -> out_en high one cycle after the 8th bit, out_d=8'hA5, busy high for 7 cycles, err=0.
- 0x3C with bit_valid low for 2 cycles between each bit -> exactly one out_en pulse, out_d=8'h3C, all state held during the gaps.
- 3 bits of a frame, then sof with 0x3C -> one pulse only, out_d=8'h3C.
- reset asserted after 5 bits of 0xFF -> out_en never pulses, out_d=0, busy=0 next cycle; a following full 0xFF frame loads out_d=8'hFF.
- 0x01, then sof on the out_en cycle with 0x80 -> two pulses 8 cycles apart, out_d=8'h01 then 8'h80.
- With PARITY_EN: 0xA5 plus parity 0 -> out_en, out_d=8'hA5. Then 0x5A plus parity 1 -> err pulse, no out_en, out_d stays 8'hA5.
